// File: rtl/reg_files_pkg.sv
// ---------------------------------------------------------------------------
// reg_files_pkg
// Shared constants and types for the 16-entry ARM-style register file.
//   REG_W  : data width of every register and of the PC
//   REG_N  : architectural register count (R0-R15, R15 has no storage)
//   LR_IDX : link register number (R14), target of branch-and-link
//   PC_IDX : program counter number (R15), reads return the live PC
// ---------------------------------------------------------------------------
package reg_files_pkg;

  localparam int REG_W = 32;
  localparam int REG_N = 16;

  localparam logic [3:0] LR_IDX = 4'd14;
  localparam logic [3:0] PC_IDX = 4'd15;

  typedef logic [REG_W-1:0] word_t;

  // Storage for R0-R14 only, packed so it can be passed as a single port.
  typedef logic [REG_N-2:0][REG_W-1:0] reg_bank_t;

endpackage : reg_files_pkg

// File: rtl/reg_files_rf_read_mux.sv
// ---------------------------------------------------------------------------
// rf_read_mux
// Purely combinational 16:1 read multiplexer for one register-file read port.
// Addresses 0-14 select the stored registers; address 15 returns the PC.
// Ports:
//   i_regs : stored contents of R0-R14
//   i_addr : 4-bit register number
//   i_pc   : live program counter, the value of R15
//   o_data : selected read data
// ---------------------------------------------------------------------------
module rf_read_mux
  import reg_files_pkg::*;
(
  input  reg_bank_t   i_regs,
  input  logic [3:0]  i_addr,
  input  word_t       i_pc,
  output word_t       o_data
);

  // R15 is the default; a match on any stored register overrides it. The
  // explicit compare loop keeps the 4-bit address from ever indexing past
  // the 15 stored entries.
  always_comb begin
    o_data = i_pc;
    for (int i = 0; i < REG_N - 1; i++) begin
      if (i_addr == 4'(i)) begin
        o_data = i_regs[i];
      end
    end
  end

endmodule : rf_read_mux

// File: rtl/reg_files.sv
// ---------------------------------------------------------------------------
// reg_files
// Sixteen-entry, 32-bit general-purpose register file for the multi-cycle
// CPU datapath. Two combinational read ports, one synchronous write port and
// a dedicated link write that saves the PC into R14 for branch-and-link.
// R15 is not stored; reading it returns the PC input.
// Ports:
//   clk      : system clock, writes commit on the rising edge
//   Reset    : asynchronous active-low, clears R0-R14 and blocks writes
//   RegWrite : general write enable
//   RFin     : general write data
//   Ra, Rb   : read addresses for RFout1 / RFout2
//   Rw       : general write address (writes to R15 are discarded)
//   PC       : current program counter (R15 value and link data)
//   PCtoBL   : link enable, R14 <- PC
//   RFout1   : read data for Ra
//   RFout2   : read data for Rb
// ---------------------------------------------------------------------------
module reg_files
  import reg_files_pkg::*;
(
  input  logic         clk,
  input  logic         Reset,
  input  logic         RegWrite,
  input  logic [31:0]  RFin,
  input  logic [3:0]   Ra,
  input  logic [3:0]   Rb,
  input  logic [3:0]   Rw,
  input  logic [31:0]  PC,
  input  logic         PCtoBL,
  output logic [31:0]  RFout1,
  output logic [31:0]  RFout2
);

  reg_bank_t r_regs;

  // Write port. The link write is placed after the general write so that
  // when both target R14 in the same cycle the PC wins. Rw=15 never matches
  // a stored entry, so those writes drop out naturally.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_regs <= '0;
    end else begin
      for (int i = 0; i < REG_N - 1; i++) begin
        if (RegWrite && (Rw == 4'(i))) begin
          r_regs[i] <= RFin;
        end
      end
      if (PCtoBL) begin
        r_regs[LR_IDX] <= PC;
      end
    end
  end

  rf_read_mux u_read_a (
    .i_regs (r_regs),
    .i_addr (Ra),
    .i_pc   (PC),
    .o_data (RFout1)
  );

  rf_read_mux u_read_b (
    .i_regs (r_regs),
    .i_addr (Rb),
    .i_pc   (PC),
    .o_data (RFout2)
  );

endmodule : reg_files

// File: tb/tb_reg_files.sv
// ---------------------------------------------------------------------------
// tb_reg_files
// Directed self-checking bench for reg_files. Inputs change on the falling
// edge; outputs are sampled 1 time unit after the rising edge or between
// edges for the combinational and asynchronous-reset checks.
// ---------------------------------------------------------------------------
module tb_reg_files;

  logic        clk;
  logic        Reset;
  logic        RegWrite;
  logic [31:0] RFin;
  logic [3:0]  Ra;
  logic [3:0]  Rb;
  logic [3:0]  Rw;
  logic [31:0] PC;
  logic        PCtoBL;
  logic [31:0] RFout1;
  logic [31:0] RFout2;

  int nAsserts = 0;
  int nFails   = 0;

  reg_files dut (
    .clk      (clk),
    .Reset    (Reset),
    .RegWrite (RegWrite),
    .RFin     (RFin),
    .Ra       (Ra),
    .Rb       (Rb),
    .Rw       (Rw),
    .PC       (PC),
    .PCtoBL   (PCtoBL),
    .RFout1   (RFout1),
    .RFout2   (RFout2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one set of inputs just after a falling edge.
  task automatic applyStimulus(input logic        regWrite,
                               input logic [3:0]  rw,
                               input logic [31:0] rfIn,
                               input logic        pcToBl,
                               input logic [3:0]  ra,
                               input logic [3:0]  rb);
    @(negedge clk);
    RegWrite = regWrite;
    Rw       = rw;
    RFin     = rfIn;
    PCtoBL   = pcToBl;
    Ra       = ra;
    Rb       = rb;
  endtask

  task automatic waitEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nAsserts++;
    assert (observed === expected)
    else begin
      nFails++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  initial begin
    Reset    = 1'b0;
    RegWrite = 1'b0;
    RFin     = '0;
    Ra       = 4'd0;
    Rb       = 4'd1;
    Rw       = 4'd0;
    PC       = 32'h1234_5678;
    PCtoBL   = 1'b0;

    // Reset state
    #3;
    checkOutput("reset_out1_r0", RFout1, 32'h0000_0000);
    checkOutput("reset_out2_r1", RFout2, 32'h0000_0000);
    Ra = 4'd15;
    #1;
    checkOutput("reset_out1_r15", RFout1, 32'h1234_5678);

    // Writes are blocked while reset is held
    applyStimulus(1'b1, 4'd1, 32'hAAAA_5555, 1'b1, 4'd14, 4'd1);
    waitEdge();
    checkOutput("reset_blocks_r1", RFout2, 32'h0000_0000);
    checkOutput("reset_blocks_link", RFout1, 32'h0000_0000);

    // R0 write, with no bypass before the edge
    @(negedge clk);
    Reset = 1'b1;
    RegWrite = 1'b1; Rw = 4'd0; RFin = 32'h4321_0000; PCtoBL = 1'b0;
    Ra = 4'd0; Rb = 4'd1;
    #1;
    checkOutput("r0_no_bypass", RFout1, 32'h0000_0000);
    waitEdge();
    checkOutput("r0_write", RFout1, 32'h4321_0000);

    // R1 write: disabled first, then enabled
    applyStimulus(1'b0, 4'd1, 32'h0000_4321, 1'b0, 4'd0, 4'd1);
    waitEdge();
    checkOutput("r1_disabled", RFout2, 32'h0000_0000);
    applyStimulus(1'b1, 4'd1, 32'h0000_4321, 1'b0, 4'd0, 4'd1);
    waitEdge();
    checkOutput("r1_write", RFout2, 32'h0000_4321);
    checkOutput("r0_retained", RFout1, 32'h4321_0000);

    // R14 / R15 reads, R15 follows PC combinationally
    applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 4'd14, 4'd15);
    #1;
    checkOutput("r14_initial", RFout1, 32'h0000_0000);
    checkOutput("r15_pc", RFout2, 32'h1234_5678);
    PC = 32'hA5A5_A5A5;
    #1;
    checkOutput("r15_live_pc", RFout2, 32'hA5A5_A5A5);
    PC = 32'h1234_5678;

    // Write to R15 is discarded and aliases nothing
    applyStimulus(1'b1, 4'd15, 32'hFFFF_FFFF, 1'b0, 4'd14, 4'd15);
    waitEdge();
    checkOutput("r15_write_dropped", RFout2, 32'h1234_5678);
    checkOutput("r15_write_r14", RFout1, 32'h0000_0000);
    Ra = 4'd1; Rb = 4'd0;
    #1;
    checkOutput("r15_write_r1", RFout1, 32'h0000_4321);
    checkOutput("r15_write_r0", RFout2, 32'h4321_0000);

    // Link write alone
    applyStimulus(1'b0, 4'd0, 32'h0, 1'b1, 4'd14, 4'd15);
    waitEdge();
    checkOutput("link_write", RFout1, 32'h1234_5678);

    // Link and general write both to R14: link wins
    applyStimulus(1'b1, 4'd14, 32'hDEAD_BEEF, 1'b1, 4'd14, 4'd3);
    PC = 32'h0BAD_F00D;
    waitEdge();
    checkOutput("link_wins_r14", RFout1, 32'h0BAD_F00D);
    checkOutput("link_wins_r3_untouched", RFout2, 32'h0000_0000);

    // Link and general write to different registers: both land
    applyStimulus(1'b1, 4'd3, 32'hDEAD_BEEF, 1'b1, 4'd14, 4'd3);
    PC = 32'h1357_2468;
    waitEdge();
    checkOutput("dual_write_r14", RFout1, 32'h1357_2468);
    checkOutput("dual_write_r3", RFout2, 32'hDEAD_BEEF);

    // Plain general write to R14
    applyStimulus(1'b1, 4'd14, 32'hCAFE_F00D, 1'b0, 4'd14, 4'd3);
    waitEdge();
    checkOutput("general_r14", RFout1, 32'hCAFE_F00D);

    // Asynchronous reset between edges
    applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd14);
    #1;
    checkOutput("pre_reset_r0", RFout1, 32'h4321_0000);
    #1;
    Reset = 1'b0;
    #1;
    checkOutput("async_reset_r0", RFout1, 32'h0000_0000);
    checkOutput("async_reset_r14", RFout2, 32'h0000_0000);
    Ra = 4'd15;
    #1;
    checkOutput("async_reset_r15", RFout1, 32'h1357_2468);

    // RegWrite pulse during reset has no effect
    applyStimulus(1'b1, 4'd0, 32'h5555_5555, 1'b1, 4'd0, 4'd14);
    waitEdge();
    checkOutput("reset_pulse_r0", RFout1, 32'h0000_0000);
    checkOutput("reset_pulse_r14", RFout2, 32'h0000_0000);

    // First edge after release writes
    @(negedge clk);
    Reset = 1'b1;
    RegWrite = 1'b1; Rw = 4'd2; RFin = 32'h2222_2222; PCtoBL = 1'b0;
    Ra = 4'd2; Rb = 4'd0;
    waitEdge();
    checkOutput("post_reset_r2", RFout1, 32'h2222_2222);
    checkOutput("post_reset_r0", RFout2, 32'h0000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule : tb_reg_files
